// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - multi-channel synchronised edge detector with sticky status and irq
// Optional debounce filter enabled by defining EDGE_DEBOUNCE_EN.
module multi_edge_detect #(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [CH-1:0] signal,
  input  logic [CH-1:0] rise_en,
  input  logic [CH-1:0] fall_en,
  input  logic [CH-1:0] status_clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise_flag,
  output logic [CH-1:0] fall_flag,
  output logic [CH-1:0] status,
  output logic          irq
);

  if (CH < 1) begin : g_bad_ch
    $error("multi_edge_detect: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_edge_detect: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("multi_edge_detect: DEBOUNCE_CYC must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [CH-1:0]          sync_w;
  logic [CH-1:0]          level_q, level_d;
  logic [CH-1:0]          filt_q;
  logic [CH-1:0]          rise_q, fall_q;
  logic [CH-1:0]          status_q, status_d;
  logic                   irq_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal[i]};
    end
  end

  always_comb begin
    sync_w = '0;
    for (int i = 0; i < CH; i++) sync_w[i] = sync_q[i][SYNC_STAGES-1];
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // A disagreement must persist for DEBOUNCE_CYC cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) level_d[i] = sync_w[i];
        else                                      cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  always_comb begin
    level_d = sync_w;
  end
`endif

  // Set terms are OR'd after the clear so a coincident edge wins.
  always_comb begin
    status_d = (status_q & ~status_clr) | (rise_q & rise_en) | (fall_q & fall_en);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_q  <= '0;
      filt_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      filt_q   <= level_q;
      rise_q   <= level_q & ~filt_q;
      fall_q   <= ~level_q & filt_q;
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign level     = level_q;
  assign rise_flag = rise_q;
  assign fall_flag = fall_q;
  assign status    = status_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - randomized and directed self-checking bench for multi_edge_detect
module tb_multi_edge_detect;

  localparam int CH           = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE_CYC = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int DEB = DEBOUNCE_CYC;
`else
  localparam int DEB = 1;
`endif

  logic          sys_clk;
  logic          sys_rst_n;
  logic [CH-1:0] signal, rise_en, fall_en, status_clr;
  logic [CH-1:0] level, rise_flag, fall_flag, status;
  logic          irq;

  int errors = 0;
  int checks = 0;

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .signal    (signal),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .status_clr(status_clr),
    .level     (level),
    .rise_flag (rise_flag),
    .fall_flag (fall_flag),
    .status    (status),
    .irq       (irq)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Reference model: sampled-input history, run length of disagreement, previous accepted level.
  bit            m_hist [CH][SYNC_STAGES];
  int            m_run  [CH];
  logic [CH-1:0] m_level, m_prev, m_rise, m_fall, m_status;
  logic          m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      for (int k = 0; k < SYNC_STAGES; k++) m_hist[i][k] = 1'b0;
    end
    m_level = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] n_status, n_rise, n_fall;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    m_irq = |m_status;
    for (int i = 0; i < CH; i++) begin
      n_status[i] = (m_status[i] & ~status_clr[i]) | (m_rise[i] & rise_en[i]) | (m_fall[i] & fall_en[i]);
      n_rise[i]   = m_level[i] && !m_prev[i];
      n_fall[i]   = !m_level[i] && m_prev[i];
    end
    m_prev = m_level;
    for (int i = 0; i < CH; i++) begin
      if (m_hist[i][SYNC_STAGES-1] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= DEB) begin
          m_level[i] = m_hist[i][SYNC_STAGES-1];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = signal[i];
    end
    m_status = n_status;
    m_rise   = n_rise;
    m_fall   = n_fall;
  endtask

  task automatic compare_all();
    check("level",     32'(level),     32'(m_level));
    check("rise_flag", 32'(rise_flag), 32'(m_rise));
    check("fall_flag", 32'(fall_flag), 32'(m_fall));
    check("status",    32'(status),    32'(m_status));
    check("irq",       32'(irq),       32'(m_irq));
    check("rise_fall_excl", 32'(rise_flag & fall_flag), 32'(0));
  endtask

  // Called at a negedge: apply inputs, let one active edge pass, compare at the next negedge.
  task automatic tick(input logic [CH-1:0] sig, input logic [CH-1:0] ren,
                      input logic [CH-1:0] fen, input logic [CH-1:0] clr);
    signal = sig; rise_en = ren; fall_en = fen; status_clr = clr;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic async_reset(input int hold);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_outs", 32'({level, rise_flag, fall_flag, status, irq}), 32'(0));
    for (int n = 0; n < hold; n++) tick('0, '0, '0, '0);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int pulses;
    logic [CH-1:0] sig, ren, fen, clr;

    sys_rst_n = 1'b0;
    signal = '0; rise_en = '0; fall_en = '0; status_clr = '0;
    model_reset();
    @(negedge sys_clk);
    check("reset_outs", 32'({level, rise_flag, fall_flag, status, irq}), 32'(0));
    for (int i = 0; i < 2; i++) tick('0, '0, '0, '0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick('0, '0, '0, '0);
    check("post_reset_outs", 32'({level, rise_flag, fall_flag, status, irq}), 32'(0));

    // Edge latency on channel 0: tick n has its active edge at E(n-1).
    n = 0;
    do begin
      tick(4'b0001, '0, '0, '0);
      n++;
    end while (!rise_flag[0] && n < 20);
    check("rise_latency", 32'(n - 1), 32'(SYNC_STAGES + DEB));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(4'b0001, '0, '0, '0);
      pulses += int'(rise_flag[0]);
    end
    check("single_rise_pulse", 32'(pulses), 32'(0));
    check("level0_high", 32'(level[0]), 32'(1));
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick('0, '0, '0, '0);
      pulses += int'(fall_flag[0]);
    end
    check("single_fall_pulse", 32'(pulses), 32'(1));

    // 3-cycle glitch on channel 1.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick((i < 3) ? 4'b0010 : 4'b0000, '0, '0, '0);
      pulses += int'(rise_flag[1]) + int'(fall_flag[1]);
    end
    check("glitch_flags", 32'(pulses), 32'((DEB > 3) ? 0 : 2));

    // Rise-only status on channel 2, then clear.
    for (int i = 0; i < 24; i++) tick((i < 10) ? 4'b0100 : 4'b0000, 4'b0100, 4'b0000, '0);
    check("status2_set", 32'(status[2]), 32'(1));
    check("irq_set", 32'(irq), 32'(1));
    tick('0, 4'b0100, '0, 4'b0100);
    check("status2_clr", 32'(status[2]), 32'(0));
    tick('0, 4'b0100, '0, '0);
    check("irq_clr", 32'(irq), 32'(0));

    // Set wins over clear on channel 3.
    n = 0;
    do begin
      tick(4'b1000, 4'b1000, '0, '0);
      n++;
    end while (!m_rise[3] && n < 20);
    tick(4'b1000, 4'b1000, '0, 4'b1000);
    check("set_wins", 32'(status[3]), 32'(1));

    // All channels rising together after a clean reset.
    @(negedge sys_clk);
    async_reset(2);
    for (int i = 0; i < 4; i++) tick('0, '1, '1, '0);
    n = 0;
    do begin
      tick('1, '1, '1, '0);
      n++;
    end while (rise_flag == '0 && n < 20);
    check("all_rise", 32'(rise_flag), 32'({CH{1'b1}}));
    tick('1, '1, '1, '0);
    check("all_rise_1cyc", 32'(rise_flag), 32'(0));

    // Reset in the middle of a debounce run.
    for (int i = 0; i < SYNC_STAGES + 1; i++) tick('0, '1, '1, '0);
    async_reset(1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick('0, '1, '1, '0);
      pulses += $countones(rise_flag | fall_flag);
    end
    check("no_spurious_after_rst", 32'(pulses), 32'(0));

    // Randomized traffic: mostly-held inputs with occasional glitches.
    sig = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 7) == 0) sig[i] = ~sig[i];
      ren = CH'($urandom);
      fen = CH'($urandom);
      clr = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      if (c == 400) async_reset(2);
      tick(sig, ren, fen, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
